alu_issue: RTL and testbench

Initiator-side sequencer for the ALU module. Accepts operations from the execute stage over a valid/ready handshake, drives the ALU request port (`req`, `op`, `lhs`, `rhs`), and captures the registered ALU result one cycle after issue. Returns the result with its tag over a second valid/ready handshake. Sits between the decode/execute control and the ALU; it is the only block that drives the ALU inputs.

---
 rtl/alu_issue.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_issue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//   Initiator-side sequencer for the ALU. Accepts operations from the execute
//   stage (valid/ready), drives the ALU request port, captures the registered
//   ALU result one cycle after issue and returns it, with its tag, over a
//   second valid/ready handshake. Results always leave in accept order.
//
//   Build option:
//     ALU_ISSUE_PIPE_EN undefined : 4-state FSM, one operation outstanding,
//                                   DEPTH is ignored.
//     ALU_ISSUE_PIPE_EN defined   : issue/wait valid-bit pipeline feeding a
//                                   DEPTH-entry result FIFO, credit-based
//                                   in_ready, one operation per cycle.
//
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     in_valid/in_ready     upstream handshake
//     in_op/lhs/rhs/tag     operation, operands and opaque tag
//     alu_req/op/lhs/rhs    ALU request (operands hold when alu_req=0)
//     alu_res               ALU registered result, valid the cycle after alu_req
//     out_valid/out_ready   downstream handshake
//     out_res/out_tag       result and its tag
// -----------------------------------------------------------------------------
module alu_issue #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [31:0]      in_lhs,
  input  logic [31:0]      in_rhs,
  input  logic [TAG_W-1:0] in_tag,
  output logic             alu_req,
  output logic [4:0]       alu_op,
  output logic [31:0]      alu_lhs,
  output logic [31:0]      alu_rhs,
  input  logic [31:0]      alu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("alu_issue: DEPTH must be a power of two and at least 4");
  end

  logic                w_accept;
  logic                r_rst_q;
  logic                r_vld_p1;
  logic [4:0]          r_op_p1;
  logic [31:0]         r_lhs_p1;
  logic [31:0]         r_rhs_p1;
  logic [TAG_W-1:0]    r_tag_p1;
  logic                r_vld_p2;
  logic [TAG_W-1:0]    r_tag_p2;

  assign w_accept = in_valid & in_ready;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rst_q <= 1'b1;
    else       r_rst_q <= 1'b0;
  end

  // ---- p1: issue stage, operands drive the ALU ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_op_p1  <= '0;
      r_lhs_p1 <= '0;
      r_rhs_p1 <= '0;
      r_tag_p1 <= '0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_op_p1  <= in_op;
        r_lhs_p1 <= in_lhs;
        r_rhs_p1 <= in_rhs;
        r_tag_p1 <= in_tag;
      end
    end
  end

  assign alu_req = r_vld_p1;
  assign alu_op  = r_op_p1;
  assign alu_lhs = r_lhs_p1;
  assign alu_rhs = r_rhs_p1;

  // ---- p2: wait stage, ALU result arrives this cycle ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p2 <= 1'b0;
      r_tag_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_tag_p2 <= r_tag_p1;
    end
  end

`ifdef ALU_ISSUE_PIPE_EN

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 2;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  logic [31:0]      r_fifo_res [DEPTH];
  logic [TAG_W-1:0] r_fifo_tag [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_nxt;
  logic             r_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [OCC_W-1:0] w_occ;

  assign w_push = r_vld_p2;
  assign w_pop  = r_out_valid & out_ready;

  // Credits count every op already in flight, so a push can never find the
  // FIFO full. A pop frees its slot only once r_count has updated.
  assign w_occ    = OCC_W'(r_vld_p1) + OCC_W'(r_vld_p2) + OCC_W'(r_count);
  assign in_ready = ~r_rst_q & (w_occ < OCC_W'(DEPTH));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_ONE;
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_ONE;
  end

  // ---- p3: result FIFO, head drives the output ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_res[i] <= '0;
        r_fifo_tag[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_res[r_wr_ptr] <= alu_res;
        r_fifo_tag[r_wr_ptr] <= r_tag_p2;
        r_wr_ptr             <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
    end
  end

  assign out_valid = r_out_valid;
  assign out_res   = r_fifo_res[r_rd_ptr];
  assign out_tag   = r_fifo_tag[r_rd_ptr];

`else

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_capture;
  logic             w_pop;
  logic             r_out_valid;
  logic [31:0]      r_out_res;
  logic [TAG_W-1:0] r_out_tag;

  // Only IDLE accepts, so a DONE handshake and a new accept never coincide.
  assign in_ready = ~r_rst_q & (r_state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        w_capture   = r_vld_p2;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- p3: result register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_tag   <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_res   <= alu_res;
      r_out_tag   <= r_tag_p2;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_tag   = r_out_tag;

`endif

endmodule

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
module tb_alu_issue;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_LT  = 5'd5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [31:0]      in_lhs;
  logic [31:0]      in_rhs;
  logic [TAG_W-1:0] in_tag;
  logic             alu_req;
  logic [4:0]       alu_op;
  logic [31:0]      alu_lhs;
  logic [31:0]      alu_rhs;
  logic [31:0]      alu_res;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_lhs(in_lhs), .in_rhs(in_rhs), .in_tag(in_tag),
    .alu_req(alu_req), .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
    .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag)
  );

  // Simple registered ALU standing in for the real one.
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_LT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        alu_res <= '0;
    else if (alu_req) alu_res <= alu_f(alu_op, alu_lhs, alu_rhs);
  end

  // Presents one op from a negedge, returns at the negedge after it is accepted.
  task automatic send(input logic [4:0] op, input logic [31:0] l, input logic [31:0] r,
                      input logic [TAG_W-1:0] t, output int waited);
    in_valid = 1'b1; in_op = op; in_lhs = l; in_rhs = r; in_tag = t;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_lhs = '0; in_rhs = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (in_ready  !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", in_ready);  else n_pass++;
    n_total++; if (alu_req   !== 1'b0) $display("FAIL rst_alu_req: got %0b want 0", alu_req);   else n_pass++;
    n_total++; if (alu_op    !== 5'd0) $display("FAIL rst_alu_op: got %0h want 0", alu_op);     else n_pass++;
    n_total++; if (alu_lhs   !== 32'd0) $display("FAIL rst_alu_lhs: got %0h want 0", alu_lhs);  else n_pass++;
    n_total++; if (alu_rhs   !== 32'd0) $display("FAIL rst_alu_rhs: got %0h want 0", alu_rhs);  else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_res   !== 32'd0) $display("FAIL rst_out_res: got %0h want 0", out_res);  else n_pass++;
    n_total++; if (out_tag   !== 4'd0) $display("FAIL rst_out_tag: got %0h want 0", out_tag);   else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_release_gap: got %0b want 0", in_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_ADD; in_lhs = 32'd5; in_rhs = 32'd7; in_tag = 4'd3;
    n_total++; if (in_ready !== 1'b1) $display("FAIL add_ready: got %0b want 1", in_ready); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (alu_req !== 1'b1)   $display("FAIL add_req_n1: got %0b want 1", alu_req);  else n_pass++;
    n_total++; if (alu_op  !== OP_ADD) $display("FAIL add_op: got %0h want %0h", alu_op, OP_ADD); else n_pass++;
    n_total++; if (alu_lhs !== 32'd5)  $display("FAIL add_lhs: got %0h want 5", alu_lhs);    else n_pass++;
    n_total++; if (alu_rhs !== 32'd7)  $display("FAIL add_rhs: got %0h want 7", alu_rhs);    else n_pass++;
    @(negedge clk);
    n_total++; if (alu_req !== 1'b0)   $display("FAIL add_req_n2: got %0b want 0", alu_req);  else n_pass++;
    n_total++; if (alu_lhs !== 32'd5)  $display("FAIL add_lhs_hold: got %0h want 5", alu_lhs); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL add_early_valid: got %0b want 0", out_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1) $display("FAIL add_valid_n3: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_res !== 32'd12) $display("FAIL add_res: got %0h want c", out_res);     else n_pass++;
    n_total++; if (out_tag !== 4'd3)   $display("FAIL add_tag: got %0h want 3", out_tag);     else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL add_valid_drop: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1)  $display("FAIL add_ready_back: got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_order();
    logic [31:0]      exp_res [2];
    logic [TAG_W-1:0] exp_tag [2];
    exp_res[0] = 32'hFFFF_FFFE; exp_tag[0] = 4'd1;
    exp_res[1] = 32'h0000_0001; exp_tag[1] = 4'd2;
    out_ready = 1'b1;
    fork
      begin
        int w;
        send(OP_SUB, 32'd3, 32'd5, 4'd1, w);
        n_total++; if (w >= 50) $display("FAIL order_send0: waited %0d want <50", w); else n_pass++;
        send(OP_LT, 32'hFFFF_FFFF, 32'd1, 4'd2, w);
        n_total++; if (w >= 50) $display("FAIL order_send1: waited %0d want <50", w); else n_pass++;
      end
      begin
        for (int k = 0; k < 2; k++) begin
          bit got = 1'b0;
          for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; break; end
          end
          n_total++; if (!got) $display("FAIL order_timeout%0d: got no out_valid want 1", k); else n_pass++;
          n_total++; if (out_res !== exp_res[k]) $display("FAIL order_res%0d: got %0h want %0h", k, out_res, exp_res[k]); else n_pass++;
          n_total++; if (out_tag !== exp_tag[k]) $display("FAIL order_tag%0d: got %0h want %0h", k, out_tag, exp_tag[k]); else n_pass++;
        end
      end
    join
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int  w;
    bit  got = 1'b0;
    out_ready = 1'b0;
    send(OP_ADD, 32'd10, 32'd20, 4'd5, w);
    n_total++; if (w >= 50) $display("FAIL bp_send: waited %0d want <50", w); else n_pass++;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    n_total++; if (!got) $display("FAIL bp_timeout: got no out_valid want 1"); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid%0d: got %0b want 1", c, out_valid); else n_pass++;
      n_total++; if (out_res !== 32'd30) $display("FAIL bp_res%0d: got %0h want 1e", c, out_res);   else n_pass++;
      n_total++; if (out_tag !== 4'd5)   $display("FAIL bp_tag%0d: got %0h want 5", c, out_tag);    else n_pass++;
`ifndef ALU_ISSUE_PIPE_EN
      n_total++; if (in_ready !== 1'b0)  $display("FAIL bp_ready%0d: got %0b want 0", c, in_ready); else n_pass++;
`endif
      @(negedge clk);
    end
    out_ready = 1'b1;
`ifndef ALU_ISSUE_PIPE_EN
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_hs: got %0b want 0", in_ready); else n_pass++;
`endif
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_valid_after: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1)  $display("FAIL bp_ready_after: got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w;
    bit seen = 1'b0;
`ifdef ALU_ISSUE_PIPE_EN
    out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd1, 4'd1, w);
    send(OP_ADD, 32'd2, 32'd2, 4'd2, w);
    send(OP_ADD, 32'd3, 32'd3, 4'd3, w);
    repeat (2) @(negedge clk);
    n_total++; if (out_valid !== 1'b1) $display("FAIL rm_buffered: got %0b want 1", out_valid); else n_pass++;
`else
    out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd2, 4'd7, w);
    n_total++; if (alu_req !== 1'b1) $display("FAIL rm_issue: got %0b want 1", alu_req); else n_pass++;
    @(negedge clk);
`endif
    reset = 1'b1;
    #1;
    n_total++; if (in_ready  !== 1'b0)  $display("FAIL rm_in_ready: got %0b want 0", in_ready);  else n_pass++;
    n_total++; if (alu_req   !== 1'b0)  $display("FAIL rm_alu_req: got %0b want 0", alu_req);   else n_pass++;
    n_total++; if (alu_op    !== 5'd0)  $display("FAIL rm_alu_op: got %0h want 0", alu_op);     else n_pass++;
    n_total++; if (alu_lhs   !== 32'd0) $display("FAIL rm_alu_lhs: got %0h want 0", alu_lhs);   else n_pass++;
    n_total++; if (alu_rhs   !== 32'd0) $display("FAIL rm_alu_rhs: got %0h want 0", alu_rhs);   else n_pass++;
    n_total++; if (out_valid !== 1'b0)  $display("FAIL rm_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_res   !== 32'd0) $display("FAIL rm_out_res: got %0h want 0", out_res);   else n_pass++;
    n_total++; if (out_tag   !== 4'd0)  $display("FAIL rm_out_tag: got %0h want 0", out_tag);   else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b0) $display("FAIL rm_release_gap: got %0b want 0", in_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL rm_release_ready: got %0b want 1", in_ready); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_total++; if (seen !== 1'b0) $display("FAIL rm_ghost_valid: got %0b want 0", seen); else n_pass++;
  endtask

`ifdef ALU_ISSUE_PIPE_EN
  task automatic test_back_to_back();
    int a0;
    out_ready = 1'b1;
    a0 = cyc + 1;
    fork
      begin
        int w;
        for (int i = 0; i < 8; i++) begin
          send(OP_XOR, 32'(i), 32'h0000_00FF, 4'(i), w);
          n_total++; if (w != 0) $display("FAIL b2b_stall%0d: waited %0d want 0", i, w); else n_pass++;
        end
      end
      begin
        for (int k = 0; k < 8; k++) begin
          bit got = 1'b0;
          for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; break; end
          end
          n_total++; if (!got) $display("FAIL b2b_timeout%0d: got no out_valid want 1", k); else n_pass++;
          n_total++; if (cyc != a0 + 2 + k) $display("FAIL b2b_cycle%0d: got %0d want %0d", k, cyc, a0 + 2 + k); else n_pass++;
          n_total++; if (out_res !== (32'h0000_00FF ^ 32'(k))) $display("FAIL b2b_res%0d: got %0h want %0h", k, out_res, 32'h0000_00FF ^ 32'(k)); else n_pass++;
          n_total++; if (out_tag !== 4'(k)) $display("FAIL b2b_tag%0d: got %0h want %0h", k, out_tag, k); else n_pass++;
        end
      end
    join
    @(negedge clk);
  endtask

  task automatic test_credit();
    int n_acc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_ADD; in_lhs = 32'd0; in_rhs = 32'd100; in_tag = 4'd0;
    repeat (10) begin
      if (in_ready) n_acc++;
      @(negedge clk);
      in_lhs = 32'(n_acc); in_tag = 4'(n_acc);
    end
    n_total++; if (n_acc != DEPTH)     $display("FAIL cr_accepts: got %0d want %0d", n_acc, DEPTH); else n_pass++;
    n_total++; if (in_ready !== 1'b0)  $display("FAIL cr_full_ready: got %0b want 0", in_ready);  else n_pass++;
    n_total++; if (out_res !== 32'd100) $display("FAIL cr_head_res: got %0h want 64", out_res);   else n_pass++;
    n_total++; if (out_tag !== 4'd0)   $display("FAIL cr_head_tag: got %0h want 0", out_tag);     else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++; if (in_ready !== 1'b1)  $display("FAIL cr_credit_back: got %0b want 1", in_ready); else n_pass++;
    n_total++; if (out_res !== 32'd101) $display("FAIL cr_next_head: got %0h want 65", out_res);  else n_pass++;
    if (in_ready) n_acc++;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (n_acc != DEPTH + 1) $display("FAIL cr_extra_accept: got %0d want %0d", n_acc, DEPTH + 1); else n_pass++;
    n_total++; if (in_ready !== 1'b0)  $display("FAIL cr_refull: got %0b want 0", in_ready); else n_pass++;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bit got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (out_valid) begin got = 1'b1; break; end
        @(negedge clk);
      end
      n_total++; if (!got) $display("FAIL cr_drain_timeout%0d: got no out_valid want 1", k); else n_pass++;
      n_total++; if (out_res !== 32'(100 + k)) $display("FAIL cr_drain_res%0d: got %0h want %0h", k, out_res, 100 + k); else n_pass++;
      n_total++; if (out_tag !== 4'(k)) $display("FAIL cr_drain_tag%0d: got %0h want %0h", k, out_tag, k); else n_pass++;
      @(negedge clk);
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL cr_empty: got %0b want 0", out_valid); else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_order();
    test_backpressure();
`ifdef ALU_ISSUE_PIPE_EN
    test_back_to_back();
    test_credit();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
